pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter generator for the MIPS fetch stage, successor to the single-cycle PC register. Adds configurable reset and exception vectors, a BEV-selected exception vector, and a circular return-address stack (RAS) for call/return. Also adds a pending-redirect latch, so a redirect pulse that arrives during a stall is held rather than dropped. Sits in front of instruction fetch; driven by the ID/EX control and CP0.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, PC value on reset
EXC_VECTOR_BEV, 32'hBFC0_0380, exception target when bev=1
EXC_VECTOR_NORM, 32'h8000_0180, exception target when bev=0
RAS_DEPTH, 4, return-stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold pc; redirects are still captured
bev  in  1  CP0 Status.BEV; selects exception vector
take_exception  in  1  redirect pulse
take_eret  in  1  redirect pulse
take_branch  in  1  redirect pulse
take_jump_imm  in  1  redirect pulse
take_return  in  1  redirect pulse, RAS pop
take_jump_reg  in  1  redirect pulse
take_call  in  1  push link address onto RAS
branch_imm_ex  in  32  sign-extended branch offset, in words
jump_imm  in  26  J-type index
jump_reg  in  32  register target
epc  in  32  CP0 EPC
pc  out  32  current fetch address
pc4  out  32  pc + 4, combinational
pend_valid  out  1  redirect latched, awaiting stall release
ras_count  out  log2(RAS_DEPTH)+1  valid RAS entries
ras_miss  out  1  one-cycle pulse: return with empty RAS
pc_misaligned  out  1  pc[1:0] != 0, combinational

Behaviour:
- Reset (rst=0, async): pc=RESET_VECTOR, pend_valid=0, pend_target=0, ras_count=0, RAS pointer=0, ras_miss=0. Redirects asserted during reset are ignored.
- Redirect inputs are single-cycle pulses and are sampled every cycle, regardless of stall.
- Target priority, highest first:
  - exception → (bev ? EXC_VECTOR_BEV : EXC_VECTOR_NORM)
  - eret → epc
  - branch → pc4 + (branch_imm_ex << 2), mod 2^32
  - jump_imm → {pc4[31:28], jump_imm, 2'b00}
  - return → RAS top if ras_count > 0; otherwise jump_reg, with ras_miss=1 next cycle
  - jump_reg → jump_reg
- Only the winning request's side effects occur. A RAS pop happens only if take_return wins; lower-priority requests are discarded.
- stall=0, no pending: pc <= winning target, else pc4. Latency 1 cycle.
- stall=0, pend_valid=1:
  - pc <= new winner if it is exception or eret, else pend_target.
  - pend_valid <= 0. Any non-exception/eret new request in this cycle is discarded.
- stall=1: pc holds.
  - Winner present and pend_valid=0: pend_target <= target, pend_valid <= 1.
  - Winner present and pend_valid=1: replace pend_target only if the winner is exception or eret; otherwise discard.
- take_call: push link = pc4 + 4 (past the delay slot) in the cycle asserted, stall or not. Write at the pointer, pointer++ (mod RAS_DEPTH), ras_count saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten.
- Pop: pointer--, ras_count--. Applied in the cycle the return is captured, whether applied or latched.
- take_call and winning take_return in the same cycle:
  - return target = old top;
  - push overwrites that slot; pointer and ras_count unchanged.
- Pop on empty: no pointer change, ras_count stays 0.
- ras_miss is registered and clears the following cycle.
- pc_misaligned reflects pc only (e.g. after eret to an odd epc); raising the AdEL exception is the responsibility of the exception logic.

Test Plan:
- Reset release, no inputs, 3 cycles → pc = BFC00000, BFC00004, BFC00008, BFC0000C; ras_count=0, pend_valid=0.
- pc=BFC00010, stall=1, take_branch pulse with branch_imm_ex=4 → pend_valid=1, pc held. Stall drops → pc=BFC00024, pend_valid=0.
- Same cycle: take_exception, take_branch, bev=0 → pc=80000180; branch discarded; no RAS change.
- RAS_DEPTH=4: five calls from pc=0x100,0x200,0x300,0x400,0x500 (pcs set via jump_reg) → ras_count=4. Four returns → pc=0x508,0x408,0x308,0x208.
- Fifth return with ras_count=0, jump_reg=0x1234 → pc=0x1234; ras_miss=1 for exactly one cycle.
- take_eret with epc=0x80000002 → pc=0x80000002, pc_misaligned=1. Assert rst mid-stall with pend_valid=1 → pc=BFC00000 immediately; pend_valid=0, ras_count=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter generator for the fetch stage.
// Handles prioritised redirects, a pending-redirect latch that holds a redirect
// arriving during a stall, and a circular return-address stack for call/return.
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR    = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR_BEV  = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VECTOR_NORM = 32'h8000_0180,
    parameter int          RAS_DEPTH       = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stall,
    input  logic                         i_bev,
    input  logic                         i_take_exception,
    input  logic                         i_take_eret,
    input  logic                         i_take_branch,
    input  logic                         i_take_jump_imm,
    input  logic                         i_take_return,
    input  logic                         i_take_jump_reg,
    input  logic                         i_take_call,
    input  logic [31:0]                  i_branch_imm_ex,
    input  logic [25:0]                  i_jump_imm,
    input  logic [31:0]                  i_jump_reg,
    input  logic [31:0]                  i_epc,
    output logic [31:0]                  o_pc,
    output logic [31:0]                  o_pc4,
    output logic                         o_pend_valid,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_miss,
    output logic                         o_pc_misaligned
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic        r_pend_valid;
    logic        r_ras_miss;
    logic [PW-1:0] r_ras_ptr;
    logic [PW:0]   r_ras_count;
    logic [31:0]   r_ras [RAS_DEPTH];

    logic [31:0]   w_pc4;
    logic [31:0]   w_link;
    logic [31:0]   w_ras_top;
    logic [31:0]   w_target;
    logic [PW-1:0] w_top_idx;
    logic [PW-1:0] w_wr_idx;
    logic          w_win;
    logic          w_win_hi;
    logic          w_ret_win;
    logic          w_captured;
    logic          w_pop;
    logic          w_miss;
    logic          w_ras_empty;
    logic          w_ras_full;

    assign w_pc4       = r_pc + 32'd4;
    // Link skips the delay slot.
    assign w_link      = r_pc + 32'd8;
    assign w_top_idx   = r_ras_ptr - PW'(1);
    assign w_ras_top   = r_ras[w_top_idx];
    assign w_ras_empty = (r_ras_count == '0);
    assign w_ras_full  = (r_ras_count == (PW+1)'(RAS_DEPTH));

    // Pick the highest-priority redirect and its target.
    always_comb begin
        w_win     = 1'b1;
        w_win_hi  = 1'b0;
        w_ret_win = 1'b0;
        w_target  = 32'd0;
        if (i_take_exception) begin
            w_win_hi = 1'b1;
            w_target = i_bev ? EXC_VECTOR_BEV : EXC_VECTOR_NORM;
        end else if (i_take_eret) begin
            w_win_hi = 1'b1;
            w_target = i_epc;
        end else if (i_take_branch) begin
            w_target = w_pc4 + (i_branch_imm_ex << 2);
        end else if (i_take_jump_imm) begin
            w_target = {w_pc4[31:28], i_jump_imm, 2'b00};
        end else if (i_take_return) begin
            w_ret_win = 1'b1;
            w_target  = w_ras_empty ? i_jump_reg : w_ras_top;
        end else if (i_take_jump_reg) begin
            w_target = i_jump_reg;
        end else begin
            w_win = 1'b0;
        end
    end

    // A redirect takes effect (applied or latched) unless a pending one blocks it;
    // only exception/eret can override a pending redirect.
    assign w_captured = w_win && (!r_pend_valid || w_win_hi);
    assign w_pop      = w_captured && w_ret_win && !w_ras_empty;
    assign w_miss     = w_captured && w_ret_win && w_ras_empty;
    // A call alongside a pop overwrites the slot being popped.
    assign w_wr_idx   = w_pop ? w_top_idx : r_ras_ptr;

    // PC register and pending-redirect latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_ras_miss    <= 1'b0;
        end else begin
            r_ras_miss <= w_miss;
            if (!i_stall) begin
                r_pend_valid <= 1'b0;
                if (r_pend_valid) begin
                    r_pc <= w_win_hi ? w_target : r_pend_target;
                end else begin
                    r_pc <= w_win ? w_target : w_pc4;
                end
            end else if (w_captured) begin
                r_pend_target <= w_target;
                r_pend_valid  <= 1'b1;
            end
        end
    end

    // Return-address stack: push on call, pop on a captured return.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ras_ptr   <= '0;
            r_ras_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= 32'd0;
            end
        end else begin
            if (i_take_call) begin
                r_ras[w_wr_idx] <= w_link;
            end
            if (w_pop && !i_take_call) begin
                r_ras_ptr   <= r_ras_ptr - PW'(1);
                r_ras_count <= r_ras_count - (PW+1)'(1);
            end else if (i_take_call && !w_pop) begin
                r_ras_ptr <= r_ras_ptr + PW'(1);
                if (!w_ras_full) begin
                    r_ras_count <= r_ras_count + (PW+1)'(1);
                end
            end
        end
    end

    assign o_pc            = r_pc;
    assign o_pc4           = w_pc4;
    assign o_pend_valid    = r_pend_valid;
    assign o_ras_count     = r_ras_count;
    assign o_ras_miss      = r_ras_miss;
    assign o_pc_misaligned = (r_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios followed by random traffic, with a
// queue-based reference model and a scoreboard monitor.
module tb_pc_unit;

    localparam int RAS_DEPTH = 4;
    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] EBEV = 32'hBFC0_0380;
    localparam logic [31:0] ENRM = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 0, bev = 0, exc = 0, eret = 0, br = 0, ji = 0, ret = 0, jr = 0, call = 0;
    logic [31:0] bimm = 0, jreg = 0, epc = 0;
    logic [25:0] jimm = 0;

    logic [31:0] o_pc, o_pc4;
    logic        o_pend_valid, o_ras_miss, o_pc_misaligned;
    logic [2:0]  o_ras_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR_BEV(EBEV), .EXC_VECTOR_NORM(ENRM),
              .RAS_DEPTH(RAS_DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(st), .i_bev(bev),
        .i_take_exception(exc), .i_take_eret(eret), .i_take_branch(br),
        .i_take_jump_imm(ji), .i_take_return(ret), .i_take_jump_reg(jr),
        .i_take_call(call), .i_branch_imm_ex(bimm), .i_jump_imm(jimm),
        .i_jump_reg(jreg), .i_epc(epc),
        .o_pc(o_pc), .o_pc4(o_pc4), .o_pend_valid(o_pend_valid),
        .o_ras_count(o_ras_count), .o_ras_miss(o_ras_miss),
        .o_pc_misaligned(o_pc_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [2:0]  cnt;
        logic        miss;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: the stack is a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_pend_tgt;
    logic        m_pend;
    logic        m_miss;
    logic [31:0] m_ras[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_pend = 0; m_pend_tgt = 0; m_miss = 0;
        m_ras.delete();
    endtask

    // One clock of architectural behaviour given the current inputs.
    task automatic model_step();
        logic [31:0] pc4, tgt;
        int kind;     // 0 none, 1 exception, 2 eret, 3 other, 4 return
        logic hi, cap, nmiss;
        pc4 = m_pc + 32'd4;
        tgt = 0;
        kind = 0;
        if (exc)       begin kind = 1; tgt = bev ? EBEV : ENRM; end
        else if (eret) begin kind = 2; tgt = epc; end
        else if (br)   begin kind = 3; tgt = pc4 + bimm * 4; end
        else if (ji)   begin kind = 3; tgt = {pc4[31:28], jimm, 2'b00}; end
        else if (ret)  begin kind = 4; tgt = (m_ras.size() > 0) ? m_ras[$] : jreg; end
        else if (jr)   begin kind = 3; tgt = jreg; end
        hi    = (kind == 1) || (kind == 2);
        cap   = (kind != 0) && (!m_pend || hi);
        nmiss = cap && (kind == 4) && (m_ras.size() == 0);
        if (cap && kind == 4 && m_ras.size() > 0) void'(m_ras.pop_back());
        if (call) begin
            m_ras.push_back(pc4 + 32'd4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        if (!st) begin
            if (m_pend) m_pc = hi ? tgt : m_pend_tgt;
            else        m_pc = (kind != 0) ? tgt : pc4;
            m_pend = 0;
        end else if (cap) begin
            m_pend_tgt = tgt;
            m_pend = 1;
        end
        m_miss = nmiss;
    endtask

    // Issue the current inputs for one cycle, queue the expectation, then clear pulses.
    task automatic cyc();
        exp_t e;
        model_step();
        e.pc = m_pc; e.pend = m_pend; e.cnt = 3'(m_ras.size()); e.miss = m_miss;
        exp_q.push_back(e);
        @(negedge clk);
        st = 0; exc = 0; eret = 0; br = 0; ji = 0; ret = 0; jr = 0; call = 0;
    endtask

    // Scoreboard monitor.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", o_pc, e.pc);
            chk("pc4", o_pc4, e.pc + 32'd4);
            chk("pend_valid", 32'(o_pend_valid), 32'(e.pend));
            chk("ras_count", 32'(o_ras_count), 32'(e.cnt));
            chk("ras_miss", 32'(o_ras_miss), 32'(e.miss));
            chk("pc_misaligned", 32'(o_pc_misaligned), 32'(e.pc[1:0] != 2'b00));
        end
    end

    initial begin
        logic [31:0] addrs [5];
        logic [31:0] rets [4];
        addrs = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
        rets  = '{32'h508, 32'h408, 32'h308, 32'h208};
        model_reset();
        exc = 1; jr = 1; jreg = 32'hDEAD_0000;
        repeat (2) @(negedge clk);
        chk("reset_pc", o_pc, RV);
        chk("reset_pend", 32'(o_pend_valid), 0);
        chk("reset_cnt", 32'(o_ras_count), 0);
        exc = 0; jr = 0;
        rst_n = 1;

        repeat (3) cyc();
        chk("seq_pc3", o_pc, 32'hBFC0_000C);
        cyc();
        st = 1; br = 1; bimm = 32'd4;
        cyc();
        chk("stall_pend", 32'(o_pend_valid), 1);
        chk("stall_hold", o_pc, 32'hBFC0_0010);
        cyc();
        chk("pend_release", o_pc, 32'hBFC0_0024);

        exc = 1; br = 1; bev = 0;
        cyc();
        chk("exc_prio", o_pc, ENRM);

        for (int i = 0; i < 5; i++) begin
            jr = 1; jreg = addrs[i];
            cyc();
            call = 1;
            cyc();
        end
        chk("ras_full", 32'(o_ras_count), 4);
        for (int i = 0; i < 4; i++) begin
            ret = 1;
            cyc();
            chk("ret_pc", o_pc, rets[i]);
        end
        ret = 1; jreg = 32'h1234;
        cyc();
        chk("miss_pc", o_pc, 32'h1234);
        chk("miss_set", 32'(o_ras_miss), 1);
        cyc();
        chk("miss_clear", 32'(o_ras_miss), 0);

        eret = 1; epc = 32'h8000_0002;
        cyc();
        chk("eret_pc", o_pc, 32'h8000_0002);
        chk("misaligned", 32'(o_pc_misaligned), 1);
        call = 1;
        cyc();
        st = 1; br = 1;
        cyc();
        chk("pre_rst_pend", 32'(o_pend_valid), 1);
        st = 1;
        rst_n = 0;
        #1;
        chk("async_rst_pc", o_pc, RV);
        chk("async_rst_pend", 32'(o_pend_valid), 0);
        chk("async_rst_cnt", 32'(o_ras_count), 0);
        model_reset();
        st = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int n = 0; n < 3000; n++) begin
            st   = ($urandom_range(0, 99) < 30);
            bev  = 1'($urandom);
            exc  = ($urandom_range(0, 99) < 4);
            eret = ($urandom_range(0, 99) < 5);
            br   = ($urandom_range(0, 99) < 10);
            ji   = ($urandom_range(0, 99) < 8);
            ret  = ($urandom_range(0, 99) < 15);
            jr   = ($urandom_range(0, 99) < 8);
            call = ($urandom_range(0, 99) < 20);
            bimm = 32'($signed($urandom_range(0, 2047)) - 1024);
            jimm = 26'($urandom);
            jreg = {$urandom} & 32'hFFFF_FFFC;
            epc  = $urandom;
            cyc();
        end
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
